pipelined_csel_adder: RTL

Parametrised, pipelined carry-select adder/subtractor for the datapath. WIDTH-bit operands are split into BLOCK-bit blocks, and each block is resolved in its own pipeline stage by a carry-select pair. Operands enter and results leave through valid/ready handshakes, with full backpressure. One operation is accepted per cycle, and results emerge in order with fixed latency.

---
 rtl/pipelined_csel_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit block resolved per stage,
// valid/ready on both ends, whole pipe freezes while the output is held.

module csel_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK{1'b0}}, c_i};
endmodule

module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overFlow,
  output logic             busy
);
  localparam int NBLK = WIDTH / BLOCK;

  logic             stall, acc;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic [NBLK-1:0]  vld_pipe;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;
  assign acc      = in_valid && in_ready;
  assign beff     = SUB ? ~B : B;
  assign ceff     = SUB ? ~Cin : Cin;

  always_ff @(posedge clk) begin
    if (rst)         vld_pipe <= '0;
    else if (!stall) vld_pipe <= NBLK'({vld_pipe, acc});
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_st
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;

    // a_in/b_in: operand bits not yet consumed; low block belongs to this stage
    logic [WIDTH-LO-1:0] a_in, b_in;
    logic [HI-1:0]       sum_d, sum_q;
    logic [BLOCK-1:0]    s_blk;
    logic                c_d, c_q, sa_d, sa_q, sb_d, sb_q;

    if (k == 0) begin : g_first
      assign a_in  = A;
      assign b_in  = beff;
      assign sa_d  = A[WIDTH-1];
      assign sb_d  = beff[WIDTH-1];
      csel_block #(.BLOCK(BLOCK)) u_add (
        .a_i(a_in[BLOCK-1:0]), .b_i(b_in[BLOCK-1:0]), .c_i(ceff), .s_o(s_blk), .c_o(c_d)
      );
      assign sum_d = s_blk;
    end else begin : g_sel
      logic [BLOCK-1:0] s0, s1;
      logic             c0, c1;
      assign a_in = g_st[k-1].g_op.a_q;
      assign b_in = g_st[k-1].g_op.b_q;
      assign sa_d = g_st[k-1].sa_q;
      assign sb_d = g_st[k-1].sb_q;
      csel_block #(.BLOCK(BLOCK)) u_c0 (
        .a_i(a_in[BLOCK-1:0]), .b_i(b_in[BLOCK-1:0]), .c_i(1'b0), .s_o(s0), .c_o(c0)
      );
      csel_block #(.BLOCK(BLOCK)) u_c1 (
        .a_i(a_in[BLOCK-1:0]), .b_i(b_in[BLOCK-1:0]), .c_i(1'b1), .s_o(s1), .c_o(c1)
      );
      assign s_blk = g_st[k-1].c_q ? s1 : s0;
      assign c_d   = g_st[k-1].c_q ? c1 : c0;
      assign sum_d = {s_blk, g_st[k-1].sum_q};
    end

    if (k < NBLK-1) begin : g_op
      logic [WIDTH-HI-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[WIDTH-LO-1:BLOCK];
          b_q <= b_in[WIDTH-LO-1:BLOCK];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        sa_q  <= 1'b0;
        sb_q  <= 1'b0;
      end else if (!stall) begin
        sum_q <= sum_d;
        c_q   <= c_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
      end
    end
  end

  assign out_valid = vld_pipe[NBLK-1];
  assign busy      = |vld_pipe;
  assign S         = g_st[NBLK-1].sum_q;
  assign Cout      = g_st[NBLK-1].c_q;
  assign overFlow  = (g_st[NBLK-1].sa_q == g_st[NBLK-1].sb_q) &&
                     (g_st[NBLK-1].sum_q[WIDTH-1] != g_st[NBLK-1].sa_q);
endmodule
